conv_enc_ctrl: RTL and testbench

Frame sequencer for the programmable rate-1/2 encoder conv_enc.
- Per frame: programs both encoder generator masks, then clears the encoder shift register with N zero shifts.
- Streams a frame of input bits into the encoder under valid/ready handshake, then appends N-1 zero tail bits.
- Presents each encoded 2-bit symbol downstream with valid/ready and a last marker.
- Stalls the encoder, which shifts every cycle its load_mask is 0, by re-loading mask0 with its own shadow value.

---
 rtl/conv_enc_ctrl.sv | 131 +++++++++++++
 tb/tb_conv_enc_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_enc_ctrl.sv
// conv_enc_ctrl: frame sequencer for conv_enc; define CONV_ENC_CTRL_ABORT_EN to add abort/aborted
module conv_enc_ctrl #(
  parameter int N = 6,
  parameter int MAX_LEN = 1024,
  parameter int LW = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [N-1:0]  cfg_mask0,
  input  logic [N-1:0]  cfg_mask1,
  input  logic [LW-1:0] frame_len,
  output logic          busy,
  input  logic          in_valid,
  input  logic          in_bit,
  output logic          in_ready,
  output logic          out_valid,
  output logic [1:0]    out_sym,
  output logic          out_last,
  input  logic          out_ready,
  output logic          done,
  output logic          enc_data_in,
  output logic [1:0]    enc_load_mask,
  output logic [N-1:0]  enc_mask,
  input  logic [1:0]    enc_data_out
`ifdef CONV_ENC_CTRL_ABORT_EN
  ,
  input  logic          abort,
  output logic          aborted
`endif
);
  localparam int CW = LW > $clog2(N + 1) ? LW : $clog2(N + 1);
  typedef enum logic [2:0] {IDLE, CFG0, CFG1, CLEAR, DATA, TAIL, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [N-1:0] m0, m1;
  logic [LW-1:0] len;
  logic [CW-1:0] cnt, cnt_n;
  logic emit, emit_last, can_emit, abt;
  assign can_emit = !out_valid || out_ready;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign out_sym = enc_data_out;
`ifdef CONV_ENC_CTRL_ABORT_EN
  assign abt = abort && busy;
  always_ff @(posedge clk)
    aborted <= !reset && abt;
`else
  assign abt = 1'b0;
`endif
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    emit = 1'b0;
    emit_last = 1'b0;
    in_ready = 1'b0;
    enc_load_mask = 2'b01;
    enc_mask = m0;
    enc_data_in = 1'b0;
    if (abt) begin
      state_n = IDLE;
      cnt_n = '0;
    end else begin
      case (state)
        IDLE: state_n = start ? CFG0 : IDLE;
        CFG0: state_n = CFG1;
        CFG1: begin
          enc_load_mask = 2'b10;
          enc_mask = m1;
          state_n = CLEAR;
        end
        CLEAR: begin
          enc_load_mask = 2'b00;
          cnt_n = cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            cnt_n = '0;
            state_n = len == '0 ? DONE : DATA;
          end
        end
        DATA: begin
          in_ready = can_emit;
          if (in_valid && can_emit) begin
            enc_load_mask = 2'b00;
            enc_data_in = in_bit;
            emit = 1'b1;
            cnt_n = cnt + CW'(1);
            if (cnt == CW'(len) - CW'(1)) begin
              cnt_n = '0;
              state_n = TAIL;
            end
          end
        end
        TAIL: begin
          if (can_emit) begin
            enc_load_mask = 2'b00;
            emit = 1'b1;
            cnt_n = cnt + CW'(1);
            if (cnt == CW'(N - 2)) begin
              cnt_n = '0;
              emit_last = 1'b1;
              state_n = DRAIN;
            end
          end
        end
        DRAIN: state_n = (out_valid && out_ready && out_last) ? DONE : DRAIN;
        DONE: state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      m0 <= '0;
      m1 <= '0;
      len <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (state == IDLE && start) begin
        m0 <= cfg_mask0;
        m1 <= cfg_mask1;
        len <= frame_len > LW'(MAX_LEN) ? LW'(MAX_LEN) : frame_len;
      end
      out_valid <= !abt && (emit || (out_valid && !out_ready));
      out_last <= !abt && (emit ? emit_last : out_last && !out_ready);
    end
  end
endmodule

// File: tb/tb_conv_enc_ctrl.sv
// tb_conv_enc_ctrl: scoreboard bench for conv_enc_ctrl driving a behavioural conv_enc
module tb_conv_enc_ctrl;
  localparam int N = 6;
  localparam int MAX_LEN = 20;
  localparam int LW = $clog2(MAX_LEN + 1);
  logic clk = 1'b0;
  logic reset, start, busy, in_valid, in_bit, in_ready, out_valid, out_last, out_ready, done;
  logic [N-1:0] cfg_mask0, cfg_mask1, enc_mask;
  logic [LW-1:0] frame_len;
  logic [1:0] out_sym, enc_load_mask, enc_data_out;
  logic enc_data_in, abort, aborted;
  logic [N-1:0] sr, gm0, gm1, scr_val, cur_m0;
  logic scr;
  logic [MAX_LEN-1:0] pat;
  logic [2:0] q[$];
  logic [2:0] exp_e;
  logic [1:0] prev_sym;
  logic prev_stall = 1'b0;
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  conv_enc_ctrl #(.N(N), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_mask0(cfg_mask0), .cfg_mask1(cfg_mask1),
    .frame_len(frame_len), .busy(busy), .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
    .out_valid(out_valid), .out_sym(out_sym), .out_last(out_last), .out_ready(out_ready), .done(done),
    .enc_data_in(enc_data_in), .enc_load_mask(enc_load_mask), .enc_mask(enc_mask),
`ifdef CONV_ENC_CTRL_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .enc_data_out(enc_data_out));
`ifndef CONV_ENC_CTRL_ABORT_EN
  assign aborted = 1'b0;
`endif

  // attached encoder: new bit enters at the MSB; scr preloads junk to prove CLEAR works
  always_ff @(posedge clk) begin
    if (scr) sr <= scr_val;
    else if (enc_load_mask == 2'b00) sr <= {enc_data_in, sr[N-1:1]};
    if (enc_load_mask[0]) gm0 <= enc_mask;
    if (enc_load_mask[1]) gm1 <= enc_mask;
  end
  assign enc_data_out = {^(sr & gm1), ^(sr & gm0)};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // output k is the convolution of the zero-prefixed bit stream (data then N-1 zeros) with each mask
  function automatic void push_model(input logic [N-1:0] a, input logic [N-1:0] b, input int eff);
    int tot;
    logic g0, g1, x;
    tot = eff == 0 ? 0 : eff + N - 1;
    for (int k = 0; k < tot; k++) begin
      g0 = 1'b0;
      g1 = 1'b0;
      for (int j = 0; j < N; j++)
        if (k >= j) begin
          x = (k - j < eff) ? pat[k-j] : 1'b0;
          g0 ^= a[N-1-j] & x;
          g1 ^= b[N-1-j] & x;
        end
      q.push_back({k == tot - 1, g1, g0});
    end
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!reset && !abort) begin
        if (prev_stall) chk("hold_sym", {29'b0, out_valid, out_sym}, {29'b0, 1'b1, prev_sym});
        if (out_valid && !out_ready) begin
          chk("stall_in_ready", 32'(in_ready), 0);
          chk("stall_load_mask", 32'(enc_load_mask), 1);
          chk("stall_mask", 32'(enc_mask), 32'(cur_m0));
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL extra_sym: got sym %0h last %0b, expected none at %0t", out_sym, out_last, $time);
          end else begin
            exp_e = q.pop_front();
            chk("sym_last", 32'({out_last, out_sym}), 32'(exp_e));
          end
        end
        if (done) chk("done_all_syms", q.size(), 0);
      end
      prev_stall = out_valid && !out_ready && !reset && !abort;
      prev_sym = out_sym;
    end
  end

  // vmode 1: random in_valid; rmode 1: random out_ready, 2: 5-cycle stall after first bit;
  // kill 1: reset in TAIL, 2: abort after 2 bits
  task automatic run_frame(input logic [N-1:0] a, input logic [N-1:0] b, input int flen,
                           input int vmode, input int rmode, input int kill);
    int eff, cyc, idx, first_rdy, stall_left, post, done_cyc, budget;
    bit stalled, fin;
    eff = flen > MAX_LEN ? MAX_LEN : flen;
    budget = 60 * (eff + N) + 100;
    push_model(a, b, eff);
    @(negedge clk);
    start = 1'b1;
    cfg_mask0 = a;
    cfg_mask1 = b;
    frame_len = LW'(flen);
    cur_m0 = a;
    cyc = 0; idx = 0; first_rdy = -1; stall_left = 0; post = 0; done_cyc = -1;
    stalled = 0; fin = 0;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        done_cyc = cyc;
        start = 1'b0;
        fin = 1;
      end else if (cyc > budget) begin
        n_checks++;
        n_fail++;
        $display("FAIL timeout: no done after %0d cycles, required within %0d", cyc, budget);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        fin = 1;
      end else begin
        start = 1'($urandom_range(0, 1));
        cfg_mask0 = N'($urandom);
        cfg_mask1 = N'($urandom);
        frame_len = LW'($urandom);
        if (rmode == 2 && idx == 1 && !stalled) begin
          stalled = 1;
          stall_left = 5;
        end
        out_ready = rmode == 1 ? ($urandom_range(0, 2) != 0) : (stall_left == 0);
        if (stall_left > 0) stall_left--;
        in_valid = vmode == 1 ? ($urandom_range(0, 3) != 0) : 1'b1;
        in_bit = idx < eff ? pat[idx] : 1'($urandom);
        if (idx == eff) post++;
        if ((kill == 1 && idx == eff && post == 3) || (kill == 2 && idx == 2)) begin
          start = 1'b0;
          in_valid = 1'b0;
          out_ready = 1'b0;
          if (kill == 1) reset = 1'b1;
`ifdef CONV_ENC_CTRL_ABORT_EN
          else abort = 1'b1;
`endif
          @(negedge clk);
          reset = 1'b0;
          abort = 1'b0;
          chk("kill_busy", 32'(busy), 0);
          chk("kill_out_valid", 32'(out_valid), 0);
          chk("kill_out_last", 32'(out_last), 0);
          chk("kill_in_ready", 32'(in_ready), 0);
          chk("kill_done", 32'(done), 0);
          if (kill == 2) chk("aborted_set", 32'(aborted), 1);
          q.delete();
          repeat (3) begin
            @(negedge clk);
            chk("kill_no_done", 32'(done), 0);
            chk("aborted_pulse", 32'(aborted), 0);
          end
          fin = 1;
        end else begin
          #1;
          if (in_ready && first_rdy < 0) first_rdy = cyc;
          if (in_valid && in_ready) idx++;
        end
      end
    end
    if (kill == 0) begin
      if (eff == 0) begin
        chk("len0_done_cycle", done_cyc, N + 3);
        chk("len0_no_ready", first_rdy, -1);
      end else begin
        chk("first_ready_cycle", first_rdy, N + 3);
        chk("bits_accepted", idx, eff);
      end
      @(negedge clk);
      chk("done_pulse_width", 32'(done), 0);
      chk("idle_after_done", 32'(busy), 0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0; abort = 1'b0;
    cfg_mask0 = '0; cfg_mask1 = '0; frame_len = '0; cur_m0 = '0; pat = '0;
    scr = 1'b1;
    scr_val = N'($urandom);
    repeat (3) @(negedge clk);
    scr = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_done", 32'(done), 0);
    reset = 1'b0;
    pat = MAX_LEN'(3'b101);
    run_frame(6'b100000, 6'b100001, 3, 0, 0, 0);
    run_frame(6'b100000, 6'b100001, 3, 0, 2, 0);
    run_frame(6'b100000, 6'b100001, 0, 0, 0, 0);
    run_frame(6'b100000, 6'b100001, 3, 0, 0, 0);
    pat = MAX_LEN'($urandom_range(0, 15));
    run_frame(6'b111101, 6'b101011, 4, 0, 0, 0);
    pat = MAX_LEN'(3'b101);
    run_frame(6'b100000, 6'b100001, 3, 0, 0, 1);
    run_frame(6'b100000, 6'b100001, 3, 0, 0, 0);
`ifdef CONV_ENC_CTRL_ABORT_EN
    run_frame(6'b100000, 6'b100001, 3, 0, 0, 2);
    run_frame(6'b100000, 6'b100001, 3, 0, 0, 0);
`endif
    pat = MAX_LEN'($urandom);
    run_frame(N'($urandom), N'($urandom), 31, 1, 1, 0);
    repeat (15) begin
      @(negedge clk);
      scr = 1'b1;
      scr_val = N'($urandom);
      @(negedge clk);
      scr = 1'b0;
      pat = MAX_LEN'($urandom);
      run_frame(N'($urandom), N'($urandom), $urandom_range(0, MAX_LEN), 1, 1, 0);
    end
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
